// File: rtl/seg_scan_driver.sv
// seg_scan_driver: self-timed multiplexed seven-segment display driver.
// The driver owns a refresh prescaler, a digit counter and a blink frame
// counter. Each digit slot is resolved in this order: blanking, blink,
// not-ready hold pattern, then the caller's digit pattern. The resolved
// slot is then gated by a 16-level brightness duty. All pin-facing
// outputs are registered. digit_idx and frame_tick are registered in the
// same cycle as sseg and AN, so they line up with the digit being driven.
module seg_scan_driver #(
    parameter int                    NUM_DIGITS   = 8,
    parameter int                    SEG_W        = 7,
    parameter int                    DIV_LOG2     = 17,
    parameter int                    BLINK_FRAMES = 64,
    parameter logic [SEG_W-1:0]      BLANK_PAT    = 7'b111_1111,
    parameter logic [SEG_W-1:0]      HOLD_PAT     = 7'b000_0001,
    parameter logic [NUM_DIGITS-1:0] HOLD_MASK    = 8'b1100_0000,
    localparam int                   IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic [3:0]                  bright,
    input  logic                        ready,
    output logic [SEG_W-1:0]            sseg,
    output logic [NUM_DIGITS-1:0]       AN,
    output logic [IDX_W-1:0]            digit_idx,
    output logic                        frame_tick
);

    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_LOG2-1:0] PRE_ONES = {DIV_LOG2{1'b1}};
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Counter state
    // ------------------------------------------------------------------
    logic [DIV_LOG2-1:0] prescaler_r;
    logic [IDX_W-1:0]    idx_r;
    logic [FRM_W-1:0]    frame_cnt_r;
    logic                blink_phase_r;

    logic [DIV_LOG2-1:0] prescaler_nxt_s;
    logic [IDX_W-1:0]    idx_nxt_s;
    logic [FRM_W-1:0]    frame_cnt_nxt_s;
    logic                blink_phase_nxt_s;

    logic                pre_wrap_s;
    logic                idx_last_s;
    logic                frame_last_s;
    logic                tick_s;

    // ------------------------------------------------------------------
    // Slot resolution signals
    // ------------------------------------------------------------------
    logic [SEG_W-1:0]      dig_sel_s;
    logic                  blank_sel_s;
    logic                  blink_sel_s;
    logic                  hold_sel_s;
    logic [NUM_DIGITS-1:0] an_lit_s;
    logic [3:0]            phase_s;
    logic                  bright_ok_s;
    logic [SEG_W-1:0]      sseg_s;
    logic [NUM_DIGITS-1:0] an_s;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [SEG_W-1:0]      sseg_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [IDX_W-1:0]      digit_idx_r;
    logic                  frame_tick_r;

    assign pre_wrap_s   = (prescaler_r == PRE_ONES);
    assign idx_last_s   = (idx_r == IDX_LAST);
    assign frame_last_s = (frame_cnt_r == FRM_LAST);
    // The scan wraps on the last cycle of the last digit. Only enabled
    // cycles count, so no wrap occurs while the counters are frozen.
    assign tick_s       = enable & pre_wrap_s & idx_last_s;

    // Brightness phase is the top nibble of the prescaler. Each slot is
    // therefore split into 16 equal sub-periods.
    assign phase_s      = prescaler_r[DIV_LOG2-1 -: 4];
    assign bright_ok_s  = (phase_s <= bright);

    // Compute the next values of the prescaler, digit, frame and blink counters.
    always_comb begin
        prescaler_nxt_s   = prescaler_r;
        idx_nxt_s         = idx_r;
        frame_cnt_nxt_s   = frame_cnt_r;
        blink_phase_nxt_s = blink_phase_r;
        if (enable) begin
            prescaler_nxt_s = prescaler_r + DIV_LOG2'(1'b1);
            if (pre_wrap_s) begin
                if (idx_last_s) begin
                    idx_nxt_s = {IDX_W{1'b0}};
                    if (frame_last_s) begin
                        frame_cnt_nxt_s   = {FRM_W{1'b0}};
                        blink_phase_nxt_s = ~blink_phase_r;
                    end else begin
                        frame_cnt_nxt_s   = frame_cnt_r + FRM_W'(1'b1);
                    end
                end else begin
                    idx_nxt_s = idx_r + IDX_W'(1'b1);
                end
            end else begin
                idx_nxt_s = idx_r;
            end
        end else begin
            prescaler_nxt_s = prescaler_r;
        end
    end

    // Counter state register: synchronous reset, frozen while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r   <= {DIV_LOG2{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            frame_cnt_r   <= {FRM_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else begin
            prescaler_r   <= prescaler_nxt_s;
            idx_r         <= idx_nxt_s;
            frame_cnt_r   <= frame_cnt_nxt_s;
            blink_phase_r <= blink_phase_nxt_s;
        end
    end

    // Select the current digit's pattern and mask bits. The select uses a
    // constant-index loop, so a non-power-of-2 digit count never indexes
    // out of range.
    always_comb begin
        dig_sel_s   = BLANK_PAT;
        blank_sel_s = 1'b0;
        blink_sel_s = 1'b0;
        hold_sel_s  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                dig_sel_s   = digits[i*SEG_W +: SEG_W];
                blank_sel_s = blank_mask[i];
                blink_sel_s = blink_mask[i];
                hold_sel_s  = HOLD_MASK[i];
            end else begin
                dig_sel_s   = dig_sel_s;
            end
        end
    end

    // Decode the anode for the current digit. Digit i drives
    // AN[NUM_DIGITS-1-i], so digit 0 is the leftmost position.
    always_comb begin
        an_lit_s = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_lit_s[NUM_DIGITS-1-i] = (idx_r == IDX_W'(i)) ? 1'b0 : 1'b1;
        end
    end

    // Resolve the slot content in priority order, then apply brightness gating.
    always_comb begin
        sseg_s = BLANK_PAT;
        an_s   = {NUM_DIGITS{1'b1}};
        if (blank_sel_s) begin
            sseg_s = BLANK_PAT;
            an_s   = {NUM_DIGITS{1'b1}};
        end else if (blink_sel_s && blink_phase_r) begin
            sseg_s = BLANK_PAT;
            an_s   = {NUM_DIGITS{1'b1}};
        end else if (!bright_ok_s) begin
            sseg_s = BLANK_PAT;
            an_s   = {NUM_DIGITS{1'b1}};
        end else if (hold_sel_s && !ready) begin
            sseg_s = HOLD_PAT;
            an_s   = an_lit_s;
        end else begin
            sseg_s = dig_sel_s;
            an_s   = an_lit_s;
        end
    end

    // Output register. It goes dark while disabled and keeps digit_idx
    // on the frozen position.
    always_ff @(posedge clk) begin
        if (reset) begin
            sseg_r       <= BLANK_PAT;
            an_r         <= {NUM_DIGITS{1'b1}};
            digit_idx_r  <= {IDX_W{1'b0}};
            frame_tick_r <= 1'b0;
        end else if (!enable) begin
            sseg_r       <= BLANK_PAT;
            an_r         <= {NUM_DIGITS{1'b1}};
            digit_idx_r  <= idx_r;
            frame_tick_r <= 1'b0;
        end else begin
            sseg_r       <= sseg_s;
            an_r         <= an_s;
            digit_idx_r  <= idx_r;
            frame_tick_r <= tick_s;
        end
    end

    assign sseg       = sseg_r;
    assign AN         = an_r;
    assign digit_idx  = digit_idx_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scoreboard bench for seg_scan_driver.
// The reference model tracks only the number of enabled cycles since
// reset. It derives the slot position, the digit, the frame count and
// the blink phase from that number with plain division and modulo.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SW = 7;
    localparam int DL = 4;
    localparam int BF = 2;
    localparam int SLOT = 1 << DL;
    localparam logic [SW-1:0] BLANK = 7'b111_1111;
    localparam logic [SW-1:0] HOLD  = 7'b000_0001;
    localparam logic [ND-1:0] HMASK = 4'b1100;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [ND*SW-1:0]  digits;
    logic [ND-1:0]     blank_mask;
    logic [ND-1:0]     blink_mask;
    logic [3:0]        bright;
    logic              ready;
    logic [SW-1:0]     sseg;
    logic [ND-1:0]     AN;
    logic [1:0]        digit_idx;
    logic              frame_tick;

    typedef struct packed {
        logic [SW-1:0] sseg;
        logic [ND-1:0] an;
        logic [1:0]    idx;
        logic          ft;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_got;
    int   t_model = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SEG_W       (SW),
        .DIV_LOG2    (DL),
        .BLINK_FRAMES(BF),
        .BLANK_PAT   (BLANK),
        .HOLD_PAT    (HOLD),
        .HOLD_MASK   (HMASK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .digits    (digits),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .bright    (bright),
        .ready     (ready),
        .sseg      (sseg),
        .AN        (AN),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference: the expected outputs after the next edge, given the
    // current inputs and the count of enabled cycles since reset.
    function automatic exp_t predict();
        exp_t e;
        int pos, d, frames;
        bit bphase, lit;
        e.sseg = BLANK;
        e.an   = 4'b1111;
        e.idx  = 2'd0;
        e.ft   = 1'b0;
        if (reset) return e;
        pos    = t_model % SLOT;
        d      = (t_model / SLOT) % ND;
        frames = t_model / (SLOT * ND);
        bphase = ((frames / BF) % 2) == 1;
        e.idx  = 2'(d);
        if (!enable) return e;
        e.ft = (pos == SLOT - 1) && (d == ND - 1);
        lit  = !blank_mask[d] && !(blink_mask[d] && bphase) && (pos <= int'(bright));
        if (lit) begin
            e.sseg = (HMASK[d] && !ready) ? HOLD : digits[d*SW +: SW];
            e.an[ND-1-d] = 1'b0;
        end
        return e;
    endfunction

    // Issue one cycle: record the expectation for the coming edge, advance the model.
    task automatic tick();
        exp_q.push_back(predict());
        if (reset) t_model = 0;
        else if (enable) t_model++;
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare the DUT outputs on every falling edge against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {sseg, AN, digit_idx, frame_tick};
            n_tests++;
            if (mon_got !== mon_e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got sseg=%b AN=%b idx=%0d tick=%b exp sseg=%b AN=%b idx=%0d tick=%b",
                         cyc, sseg, AN, digit_idx, frame_tick,
                         mon_e.sseg, mon_e.an, mon_e.idx, mon_e.ft);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        digits     = 28'h0;
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        bright     = 4'd15;
        ready      = 1'b1;
        for (int i = 0; i < ND; i++) digits[i*SW +: SW] = 7'($urandom_range(0, 127));
        run(3);

        // basic scan, full brightness
        reset = 1'b0;
        run(300);

        // reset mid-slot at digit 2
        while ((t_model / SLOT) % ND != 2) tick();
        run(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(80);

        // brightness levels
        bright = 4'd3;
        run(128);
        bright = 4'd0;
        run(128);
        bright = 4'($urandom_range(0, 15));
        run(128);
        bright = 4'd15;

        // hold and blank priority
        ready = 1'b0;
        run(80);
        blank_mask = 4'b0100;
        run(80);
        ready = 1'b1;
        run(80);
        blank_mask = 4'b0000;

        // blink on digit 0
        blink_mask = 4'b0001;
        run(600);

        // enable freeze at digit 1, prescaler 5
        for (int k = 0; k < 200 && (t_model % (SLOT * ND)) != SLOT + 5; k++) tick();
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        run(40);

        // fully randomized traffic
        for (int k = 0; k < 2500; k++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 31) == 0) begin
                blank_mask = 4'($urandom_range(0, 15));
                blink_mask = 4'($urandom_range(0, 15));
                bright     = 4'($urandom_range(0, 15));
                ready      = 1'($urandom_range(0, 1));
                for (int i = 0; i < ND; i++) digits[i*SW +: SW] = 7'($urandom_range(0, 127));
            end
            tick();
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
